// File: rtl/ppu_bus_pkg.sv
// rtl/ppu_bus_pkg.sv - shared types for the PPU register-port bus master
package ppu_bus_pkg;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_WRITE   = 2'd1,
        OP_WRITE16 = 2'd2,
        OP_RSVD    = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        REG_CTRL    = 3'd0,
        REG_MASK    = 3'd1,
        REG_STATUS  = 3'd2,
        REG_OAMADDR = 3'd3,
        REG_OAMDATA = 3'd4,
        REG_SCROLL  = 3'd5,
        REG_ADDR    = 3'd6,
        REG_DATA    = 3'd7
    } reg_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // The reserved encoding falls back to a read so the bus is never driven by accident.
    function automatic logic op_is_read(input op_e op);
        return !(op == OP_WRITE || op == OP_WRITE16);
    endfunction

endpackage

// File: rtl/ppu_bus_master.sv
// rtl/ppu_bus_master.sv - CPU-side initiator producing timed chip-select strobes on the PPU register bus
module ppu_bus_master
    import ppu_bus_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [2:0]  req_reg,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [2:0]  ppu_addr,
    output logic        ppu_cs_n,
    output logic        ppu_rw,
    inout  wire  [7:0]  ppu_data
);

    localparam int MAX_AB  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int MAX_CYC = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);

    if (SETUP_CYC < 1) begin : g_bad_setup
        $error("ppu_bus_master: SETUP_CYC must be >= 1");
    end
    if (STROBE_CYC < 1) begin : g_bad_strobe
        $error("ppu_bus_master: STROBE_CYC must be >= 1");
    end
    if (HOLD_CYC < 1) begin : g_bad_hold
        $error("ppu_bus_master: HOLD_CYC must be >= 1");
    end

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          w16_q;
    logic          second_q;
    logic [7:0]    lo_byte_q;
    logic [7:0]    wbyte_q;
    logic          drive_q;
    logic          ready_q;
    logic          rsp_valid_q;
    logic [7:0]    rdata_q;
    logic          cs_n_q;
    logic          rw_q;
    logic [2:0]    addr_q;

    logic req_is_rd;
    logic req_is_w16;

    assign req_is_rd  = op_is_read(op_e'(req_op));
    assign req_is_w16 = (op_e'(req_op) == OP_WRITE16);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            w16_q       <= 1'b0;
            second_q    <= 1'b0;
            lo_byte_q   <= '0;
            wbyte_q     <= '0;
            drive_q     <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            cs_n_q      <= 1'b1;
            rw_q        <= 1'b1;
            addr_q      <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && ready_q) begin
                        state_q   <= ST_SETUP;
                        cnt_q     <= SETUP_LD;
                        w16_q     <= req_is_w16;
                        second_q  <= 1'b0;
                        lo_byte_q <= req_wdata[7:0];
                        wbyte_q   <= req_is_w16 ? req_wdata[15:8] : req_wdata[7:0];
                        drive_q   <= !req_is_rd;
                        ready_q   <= 1'b0;
                        rw_q      <= req_is_rd;
                        addr_q    <= req_reg;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_STROBE;
                        cnt_q   <= STROBE_LD;
                        cs_n_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_STROBE: begin
                    // Read data is captured on the edge that ends the strobe.
                    if (cnt_q == '0) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= HOLD_LD;
                        cs_n_q  <= 1'b1;
                        if (rw_q) begin
                            rdata_q <= ppu_data;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        if (w16_q && !second_q) begin
                            state_q  <= ST_SETUP;
                            cnt_q    <= SETUP_LD;
                            second_q <= 1'b1;
                            wbyte_q  <= lo_byte_q;
                        end else begin
                            state_q     <= ST_DONE;
                            rsp_valid_q <= 1'b1;
                            drive_q     <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    cs_n_q  <= 1'b1;
                    drive_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = ready_q & rst_n;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign ppu_addr  = addr_q;
    assign ppu_cs_n  = cs_n_q;
    assign ppu_rw    = rw_q;
    assign ppu_data  = (drive_q && !rw_q) ? wbyte_q : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_ppu_bus_master.sv
// tb/tb_ppu_bus_master.sv - self-checking bench for ppu_bus_master with a cycle-timeline reference model
module tb_ppu_bus_master;
    import ppu_bus_pkg::*;

    typedef struct packed {
        logic       cs;
        logic       rw;
        logic [2:0] addr;
        logic [7:0] data;
        logic       rvalid;
        logic       busy;
        logic [7:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [1:0]       vld;
    logic [1:0][1:0]  op;
    logic [1:0][2:0]  rg;
    logic [1:0][15:0] wd;
    logic [1:0]       rdy;
    logic [1:0]       rsv;
    logic [1:0][7:0]  rsd;
    logic [1:0][2:0]  ad;
    logic [1:0]       csn;
    logic [1:0]       rw;
    wire  [7:0]       bus0;
    wire  [7:0]       bus1;

    logic [7:0] rmem [2][8];
    int vectors = 0;
    int miscompares = 0;
    int scyc [2] = '{1, 3};
    int tcyc [2] = '{2, 1};
    int hcyc [2] = '{1, 2};

    ppu_bus_master dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(vld[0]), .req_ready(rdy[0]), .req_op(op[0]),
        .req_reg(rg[0]), .req_wdata(wd[0]), .rsp_valid(rsv[0]), .rsp_rdata(rsd[0]),
        .ppu_addr(ad[0]), .ppu_cs_n(csn[0]), .ppu_rw(rw[0]), .ppu_data(bus0)
    );

    ppu_bus_master #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(vld[1]), .req_ready(rdy[1]), .req_op(op[1]),
        .req_reg(rg[1]), .req_wdata(wd[1]), .rsp_valid(rsv[1]), .rsp_rdata(rsd[1]),
        .ppu_addr(ad[1]), .ppu_cs_n(csn[1]), .ppu_rw(rw[1]), .ppu_data(bus1)
    );

    // PPU responders drive only during read strobes; pullups make a released bus read 0xFF.
    assign bus0 = (!csn[0] && rw[0]) ? rmem[0][ad[0]] : 8'bzzzz_zzzz;
    assign bus1 = (!csn[1] && rw[1]) ? rmem[1][ad[1]] : 8'bzzzz_zzzz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup pu_a (bus0[i]);
        pullup pu_b (bus1[i]);
    end

    exp_t       mq [2][$];
    logic [2:0] laddr [2] = '{3'd0, 3'd0};
    logic       lrw   [2] = '{1'b1, 1'b1};
    logic [7:0] lrd   [2] = '{8'h00, 8'h00};
    logic       prev_cs0 = 1'b1;
    logic [10:0] cap [$];

    task automatic chk(input string nm, input int got, input int want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, got, got, want, want);
        end
    endtask

    // Each accepted request expands into its full per-cycle bus timeline.
    task automatic model_step(input int id, input logic [7:0] bv);
        exp_t e;
        exp_t n;
        logic exp_rdy;
        logic rd;
        int nph;
        int per;
        logic [7:0] b;
        logic [7:0] nrd;
        if (mq[id].size() != 0) e = mq[id].pop_front();
        else e = '{cs: 1'b1, rw: lrw[id], addr: laddr[id], data: 8'hFF,
                   rvalid: 1'b0, busy: 1'b0, rdata: lrd[id]};
        exp_rdy = rst_n && !e.busy;
        vectors++;
        if (csn[id] !== e.cs || rw[id] !== e.rw || ad[id] !== e.addr || bv !== e.data ||
            rsv[id] !== e.rvalid || rsd[id] !== e.rdata || rdy[id] !== exp_rdy) begin
            miscompares++;
            $display("FAIL cycle dut%0d t=%0t: got cs_n=%b rw=%b addr=%0d data=%h rsp_valid=%b rdata=%h ready=%b, want cs_n=%b rw=%b addr=%0d data=%h rsp_valid=%b rdata=%h ready=%b",
                     id, $time, csn[id], rw[id], ad[id], bv, rsv[id], rsd[id], rdy[id],
                     e.cs, e.rw, e.addr, e.data, e.rvalid, e.rdata, exp_rdy);
        end
        if (!rst_n) begin
            mq[id].delete();
            laddr[id] = 3'd0;
            lrw[id]   = 1'b1;
            lrd[id]   = 8'h00;
        end else if (vld[id] && !e.busy) begin
            rd  = !(op[id] == 2'd1 || op[id] == 2'd2);
            nph = (op[id] == 2'd2) ? 2 : 1;
            nrd = rd ? rmem[id][rg[id]] : lrd[id];
            per = scyc[id] + tcyc[id] + hcyc[id];
            for (int p = 0; p < nph; p++) begin
                b = (op[id] == 2'd2 && p == 0) ? wd[id][15:8] : wd[id][7:0];
                for (int k = 0; k < per; k++) begin
                    n.cs     = !(k >= scyc[id] && k < scyc[id] + tcyc[id]);
                    n.rw     = rd;
                    n.addr   = rg[id];
                    n.data   = rd ? (n.cs ? 8'hFF : nrd) : b;
                    n.rvalid = 1'b0;
                    n.busy   = 1'b1;
                    n.rdata  = (rd && k >= scyc[id] + tcyc[id]) ? nrd : lrd[id];
                    mq[id].push_back(n);
                end
            end
            n = '{cs: 1'b1, rw: rd, addr: rg[id], data: 8'hFF, rvalid: 1'b1, busy: 1'b1, rdata: nrd};
            mq[id].push_back(n);
            laddr[id] = rg[id];
            lrw[id]   = rd;
            lrd[id]   = nrd;
        end
    endtask

    always @(negedge clk) begin
        model_step(0, bus0);
        model_step(1, bus1);
        if (!csn[0] && prev_cs0) cap.push_back({ad[0], bus0});
        prev_cs0 = csn[0];
    end

    task automatic issue(input int id, input logic [1:0] o, input logic [2:0] r,
                         input logic [15:0] d, output int lat, output logic [7:0] rdv);
        int n;
        @(posedge clk); #1;
        vld[id] = 1'b1; op[id] = o; rg[id] = r; wd[id] = d;
        n = 0;
        do begin @(negedge clk); n++; end while (!rdy[id] && n < 50);
        chk("accept_ready", rdy[id], 1);
        @(posedge clk); #1;
        vld[id] = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsv[id] && lat < 40);
        rdv = rsd[id];
    endtask

    task automatic rand_one(input int id);
        logic [1:0]  o;
        logic [2:0]  r;
        logic [15:0] d;
        int lat;
        logic [7:0] rdv;
        o = 2'($urandom_range(0, 3));
        r = 3'($urandom_range(0, 7));
        d = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 254))};
        issue(id, o, r, d, lat, rdv);
        chk("rand_lat", lat, ((o == 2'd2) ? 2 : 1) * (scyc[id] + tcyc[id] + hcyc[id]) + 1);
        repeat ($urandom_range(0, 3)) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        logic [7:0] rdv;
        logic [1:0] sop  [5] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
        logic [2:0] sreg [5] = '{3'd1, 3'd5, 3'd7, 3'd2, 3'd4};

        rst_n = 1'b0; vld = '0; op = '0; rg = '0; wd = '0;
        for (int id = 0; id < 2; id++)
            for (int k = 0; k < 8; k++) rmem[id][k] = 8'($urandom_range(0, 254));
        rmem[0][2] = 8'hA5;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", rdy[0], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", rdy[0], 1);
        chk("rdata_reset", rsd[0], 0);
        chk("cs_n_reset", csn[0], 1);
        chk("data_reset", bus0, 8'hFF);

        issue(0, 2'd1, 3'd0, 16'h0080, lat, rdv);
        chk("write_lat", lat, 5);
        chk("write_data_released", bus0, 8'hFF);

        issue(0, 2'd0, 3'd2, 16'h0000, lat, rdv);
        chk("read_lat", lat, 5);
        chk("read_rdata", rdv, 8'hA5);

        cap.delete();
        issue(0, 2'd2, 3'd6, 16'h2108, lat, rdv);
        chk("w16_lat", lat, 9);
        chk("w16_pulses", cap.size(), 2);
        chk("w16_byte_hi", (cap.size() > 0) ? int'(cap[0]) : -1, int'({3'd6, 8'h21}));
        chk("w16_byte_lo", (cap.size() > 1) ? int'(cap[1]) : -1, int'({3'd6, 8'h08}));

        @(posedge clk); #1;
        vld[0] = 1'b1; op[0] = 2'd1; rg[0] = 3'd3; wd[0] = 16'h005A;
        n = 0;
        do begin @(negedge clk); n++; end while (csn[0] && n < 50);
        chk("strobe_seen", csn[0], 0);
        @(posedge clk); #1;
        vld[0] = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_cs_n", csn[0], 1);
        chk("rst_data_z", bus0, 8'hFF);
        chk("rst_no_rsp", rsv[0], 0);
        chk("rst_ready_low", rdy[0], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_back", rdy[0], 1);
        repeat (4) begin
            @(negedge clk);
            chk("rst_no_late_rsp", rsv[0], 0);
        end

        @(posedge clk); #1;
        vld[1] = 1'b1; op[1] = sop[0]; rg[1] = sreg[0]; wd[1] = 16'h003C;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!rdy[1] && n < 50);
            chk("b_accept", rdy[1], 1);
            @(posedge clk); #1;
            if (i < 4) begin
                op[1] = sop[i+1];
                rg[1] = sreg[i+1];
            end else begin
                vld[1] = 1'b0;
            end
            lat = 0;
            do begin @(negedge clk); lat++; end while (!rsv[1] && lat < 40);
            chk("b_lat", lat, 7);
            if (i == 2 || i == 3) chk("b_rdata_hold", rsd[1], rmem[1][7]);
            if (i == 4) chk("b_rdata_last", rsd[1], rmem[1][4]);
        end

        fork
            for (int i = 0; i < 60; i++) rand_one(0);
            for (int j = 0; j < 40; j++) rand_one(1);
        join

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ppu_bus_master.md
# ppu_bus_master

CPU-side initiator for the PPU register port. Accepts register read/write requests over a valid/ready handshake and converts each into a timed chip-select strobe on the 8-register PPU bus (select active-low, rw=1 read, rw=0 write, 3-bit register index). Provides a two-write sequence for the 16-bit scroll/VRAM-address registers and returns read data on a one-cycle response pulse. Sits between the CPU core (or test sequencer) and the PPU register decoder.

## Interface
- SETUP_CYC, 1: cycles that addr/rw/data are stable before the strobe; must be >= 1.
- STROBE_CYC, 2: cycles with ppu_cs_n low; must be >= 1.
- HOLD_CYC, 1: cycles that addr/rw/data are held after the strobe; must be >= 1.
- clk  in  1  single clock.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid & ready.
- req_op  in  2  op_e: OP_READ, OP_WRITE, OP_WRITE16.
- req_reg  in  3  register index 0..7.
- req_wdata  in  16  write data; [7:0] for OP_WRITE, [15:8] then [7:0] for OP_WRITE16.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  last read byte.
- ppu_addr  out  3  register index on bus.
- ppu_cs_n  out  1  active-low chip select.
- ppu_rw  out  1  1 = read, 0 = write.
- ppu_data  inout  8  driven only during write phases, else Z.

## Operation
- Registered FSM: IDLE, SETUP, STROBE, HOLD, DONE. One shared down-counter, width sized to the largest parameter.
- IDLE: req_ready = 1 (0 while rst_n = 0). On valid & ready, latch op/reg/wdata and go to SETUP.
- SETUP, SETUP_CYC cycles: ppu_addr = reg; ppu_rw = (op == OP_READ); ppu_cs_n = 1. On writes, ppu_data drives the current byte.
- STROBE, STROBE_CYC cycles: ppu_cs_n = 0. On reads, ppu_data is sampled into rsp_rdata at the clock edge ending the last STROBE cycle.
- HOLD, HOLD_CYC cycles: ppu_cs_n = 1; addr, rw and data are unchanged.
- After HOLD:
  - OP_WRITE16 first byte: reload the counter, select byte [7:0], return to SETUP.
  - Otherwise: go to DONE.
- DONE: rsp_valid = 1 for one cycle, then IDLE.
- ppu_rw and ppu_addr change only while ppu_cs_n = 1. This guarantees no bus contention between rw edges and the strobe.
- rsp_rdata:
  - updates only on reads;
  - holds its value across writes;
  - resets to 0.
- req_valid is ignored outside IDLE. Requests are never queued.

## Timing
- Reset values: req_ready = 0 during reset, 1 on the first cycle after. rsp_valid = 0, rsp_rdata = 0, ppu_cs_n = 1, ppu_rw = 1, ppu_addr = 0, ppu_data = Z, state = IDLE.
- Single access, accepted at edge 0:
  - SETUP occupies cycles 1..S.
  - STROBE occupies S+1..S+T.
  - HOLD occupies S+T+1..S+T+H.
  - rsp_valid is high in cycle S+T+H+1.
  - req_ready is high again in cycle S+T+H+2.
  - With defaults, rsp_valid is at cycle 5.
- OP_WRITE16: two full SETUP/STROBE/HOLD sequences back to back, then one DONE. Default rsp_valid is at cycle 9.
- Back-to-back requests: minimum one IDLE cycle between a DONE and the next SETUP.
- Reset mid-operation: at the next edge, ppu_cs_n = 1, ppu_data = Z, no rsp_valid, in-flight request discarded.
- Parameter value 0 is illegal. Flag it with an elaboration-time assertion.

## Structure
- Package ppu_bus_pkg contains:
  - op_e (OP_READ = 0, OP_WRITE = 1, OP_WRITE16 = 2; value 3 reserved and treated as OP_READ);
  - reg_e (REG_CTRL = 0, REG_MASK, REG_STATUS, REG_OAMADDR, REG_OAMDATA, REG_SCROLL, REG_ADDR, REG_DATA = 7);
  - state_e.
- Single flat module; no sub-module.
- The tristate driver on ppu_data is one continuous assign gated by write phase and !rw.

## Test plan
- Reset, then OP_WRITE reg 0 data 0x80 with defaults: ppu_addr = 0 and rw = 0 from cycle 1; cs_n low in cycles 2-3; ppu_data = 0x80 in cycles 1-4; rsp_valid at cycle 5; data Z afterwards.
- Responder model returns 0xA5 on reg 2, then OP_READ reg 2: rw = 1, ppu_data never driven by the master, rsp_rdata = 0xA5 with rsp_valid at cycle 5.
- OP_WRITE16 reg 6 data 0x2108: two cs_n pulses on addr 6 carrying 0x21 then 0x08; exactly one rsp_valid, at cycle 9.
- Assert rst_n = 0 during STROBE of a write: cs_n = 1 and data = Z at the next edge; no rsp_valid; req_ready = 1 after reset releases.
- SETUP_CYC = 3, STROBE_CYC = 1, HOLD_CYC = 2, continuous req_valid across 3 reads: each rsp at S+T+H+1 after its accept; rw/addr never change while cs_n = 0; rsp_rdata holds across an interleaved write.
